wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master.sv | 193 +++++++++++++++++++
 tb/tb_wb_cmd_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns a byte-serial command stream into single Wishbone B4
// pipelined bus cycles and returns a status byte (plus read data) on a byte
// response stream.
// Optional feature: define WB_CMD_TIMEOUT_EN to abort bus cycles that receive
// no ack/err within TIMEOUT_CYCLES cycles of entering REQ (status 0xE0).
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_vld_i,
  output logic        rx_rdy_o,
  output logic [7:0]  tx_dat_o,
  output logic        tx_vld_o,
  input  logic        tx_rdy_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_stall_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [7:0] STS_ACK     = 8'hA5;
  localparam logic [7:0] STS_ERR     = 8'hEE;
  localparam logic [7:0] STS_TIMEOUT = 8'hE0;

  // Reject out-of-range timeout settings at elaboration time
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_badTimeout
    $error("wb_cmd_master: TIMEOUT_CYCLES out of range 2..65535");
  end

  state_t      r_state;
  state_t      w_next;
  logic        r_isWrite;
  logic [1:0]  r_byteCnt;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [31:0] r_rdData;
  logic [7:0]  r_status;
  logic [2:0]  r_respIdx;
  logic [2:0]  r_respLast;
  logic [7:0]  w_respByte;
  logic        w_rxFire;
  logic        w_txFire;
  logic        w_busLive;
  logic        w_ack;
  logic        w_err;
  logic        w_timeout;
  logic        w_cmdOk;

  // Bus responses only count when the strobe was accepted or we are waiting
  assign w_busLive = ((r_state == S_REQ) && !wbm_stall_i) || (r_state == S_WAIT);
  assign w_ack     = w_busLive && wbm_ack_i;
  assign w_err     = w_busLive && wbm_err_i && !wbm_ack_i;
  assign w_rxFire  = rx_vld_i && rx_rdy_o;
  assign w_txFire  = tx_vld_o && tx_rdy_i;
  assign w_cmdOk   = (rx_dat_i == CMD_WRITE) || (rx_dat_i == CMD_READ);

  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_wdat;
  assign wbm_we_o  = r_isWrite;

`ifdef WB_CMD_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_toCnt;

  // Count cycles spent with the bus cycle open, restarting at every REQ entry
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_toCnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
      r_toCnt <= r_toCnt + 16'd1;
    end else begin
      r_toCnt <= '0;
    end
  end

  assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT)) && (r_toCnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode: frame parsing, bus handshake, response drain
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_rxFire && w_cmdOk) w_next = S_ADDR;
      S_ADDR: if (w_rxFire && (r_byteCnt == 2'd3)) w_next = r_isWrite ? S_DATA : S_REQ;
      S_DATA: if (w_rxFire && (r_byteCnt == 2'd3)) w_next = S_REQ;
      S_REQ: begin
        if (w_ack || w_err || w_timeout) w_next = S_RESP;
        else if (!wbm_stall_i)           w_next = S_WAIT;
      end
      S_WAIT: if (w_ack || w_err || w_timeout) w_next = S_RESP;
      S_RESP: if (w_txFire && (r_respIdx == r_respLast)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame payload capture, bus completion status and response byte index
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_isWrite  <= 1'b0;
      r_byteCnt  <= '0;
      r_adr      <= '0;
      r_wdat     <= '0;
      r_rdData   <= '0;
      r_status   <= '0;
      r_respIdx  <= '0;
      r_respLast <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rxFire && w_cmdOk) begin
            r_isWrite <= (rx_dat_i == CMD_WRITE);
            r_byteCnt <= '0;
          end
        end
        S_ADDR: begin
          if (w_rxFire) begin
            r_adr     <= {r_adr[23:0], rx_dat_i};
            r_byteCnt <= r_byteCnt + 2'd1;
          end
        end
        S_DATA: begin
          if (w_rxFire) begin
            r_wdat    <= {r_wdat[23:0], rx_dat_i};
            r_byteCnt <= r_byteCnt + 2'd1;
          end
        end
        S_REQ, S_WAIT: begin
          r_respIdx <= '0;
          if (w_ack) begin
            r_status   <= STS_ACK;
            r_respLast <= r_isWrite ? 3'd0 : 3'd4;
            if (!r_isWrite) r_rdData <= wbm_dat_i;
          end else if (w_err) begin
            r_status   <= STS_ERR;
            r_respLast <= 3'd0;
          end else if (w_timeout) begin
            r_status   <= STS_TIMEOUT;
            r_respLast <= 3'd0;
          end
        end
        S_RESP: begin
          if (w_txFire) r_respIdx <= r_respIdx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Select the response byte: status first, then read data MSB first
  always_comb begin
    w_respByte = r_status;
    case (r_respIdx)
      3'd1:    w_respByte = r_rdData[31:24];
      3'd2:    w_respByte = r_rdData[23:16];
      3'd3:    w_respByte = r_rdData[15:8];
      3'd4:    w_respByte = r_rdData[7:0];
      default: w_respByte = r_status;
    endcase
  end

  // Output decode from state; rx_rdy_o is also forced low while reset is held
  always_comb begin
    rx_rdy_o  = ((r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA)) && !wb_rst_i;
    wbm_cyc_o = (r_state == S_REQ) || (r_state == S_WAIT);
    wbm_stb_o = (r_state == S_REQ);
    wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
    tx_vld_o  = (r_state == S_RESP);
    tx_dat_o  = (r_state == S_RESP) ? w_respByte : 8'h00;
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed self-checking bench for wb_cmd_master.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxDat;
  logic        rxVld;
  logic        rxRdy;
  logic [7:0]  txDat;
  logic        txVld;
  logic        txRdy;
  logic        cyc, stb, we;
  logic [31:0] adr, datO, datI;
  logic [3:0]  sel;
  logic        ack, err, stall;

  int testsRun  = 0;
  int failCount = 0;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .rx_dat_i   (rxDat),
    .rx_vld_i   (rxVld),
    .rx_rdy_o   (rxRdy),
    .tx_dat_o   (txDat),
    .tx_vld_o   (txVld),
    .tx_rdy_i   (txRdy),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (datO),
    .wbm_sel_o  (sel),
    .wbm_dat_i  (datI),
    .wbm_ack_i  (ack),
    .wbm_err_i  (err),
    .wbm_stall_i(stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command byte and hold it until the DUT takes it
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    rxDat = b;
    rxVld = 1'b1;
    while (rxRdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rx_accept", rxRdy, 1);
    @(negedge clk);
    rxVld = 1'b0;
  endtask

  task automatic sendRead(input logic [31:0] a);
    applyStimulus(8'h02);
    applyStimulus(a[31:24]);
    applyStimulus(a[23:16]);
    applyStimulus(a[15:8]);
    applyStimulus(a[7:0]);
  endtask

  task automatic sendWrite(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(8'h01);
    applyStimulus(a[31:24]);
    applyStimulus(a[23:16]);
    applyStimulus(a[15:8]);
    applyStimulus(a[7:0]);
    applyStimulus(d[31:24]);
    applyStimulus(d[23:16]);
    applyStimulus(d[15:8]);
    applyStimulus(d[7:0]);
  endtask

  // Wait for a response byte, optionally stall it one cycle, then consume it
  task automatic recvByte(input string tag, input logic [7:0] exp, input bit hold);
    int n;
    n = 0;
    while (txVld !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_vld"}, txVld, 1);
    if (hold) begin
      txRdy = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_held"}, {txVld, txDat}, {1'b1, exp});
    end
    checkOutput(tag, txDat, exp);
    txRdy = 1'b1;
    @(negedge clk);
    txRdy = 1'b0;
  endtask

  // Hard stop if the sequence ever wedges
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence
  initial begin
    int stbCnt;
    int cycCnt;
    rst = 1'b1; rxDat = 8'h00; rxVld = 1'b0; txRdy = 1'b0;
    ack = 1'b0; err = 1'b0; stall = 1'b0; datI = 32'h0;
    #2;
    checkOutput("rst_cyc", cyc, 0);
    checkOutput("rst_stb", stb, 0);
    checkOutput("rst_we", we, 0);
    checkOutput("rst_adr", adr, 0);
    checkOutput("rst_dat", datO, 0);
    checkOutput("rst_sel", sel, 0);
    checkOutput("rst_txvld", txVld, 0);
    checkOutput("rst_txdat", txDat, 0);
    checkOutput("rst_rxrdy", rxRdy, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rel_rxrdy", rxRdy, 1);

    // Write, slave acks on the second WAIT cycle
    sendWrite(32'h01000010, 32'hDEADBEEF);
    checkOutput("wr_cyc", cyc, 1);
    checkOutput("wr_stb", stb, 1);
    checkOutput("wr_adr", adr, 32'h01000010);
    checkOutput("wr_dat", datO, 32'hDEADBEEF);
    checkOutput("wr_we", we, 1);
    checkOutput("wr_sel", sel, 4'hF);
    checkOutput("wr_rxrdy_req", rxRdy, 0);
    @(negedge clk);
    checkOutput("wr_wait_stb", stb, 0);
    checkOutput("wr_wait_cyc", cyc, 1);
    @(negedge clk);
    checkOutput("wr_adr_hold", adr, 32'h01000010);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput("wr_cyc_drop", cyc, 0);
    recvByte("wr_status", 8'hA5, 1'b0);
    checkOutput("wr_no_extra", txVld, 0);
    checkOutput("wr_idle_rdy", rxRdy, 1);

    // Read with three stalled strobe cycles
    sendRead(32'h02000004);
    checkOutput("rd_we", we, 0);
    checkOutput("rd_adr", adr, 32'h02000004);
    stbCnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (stb) stbCnt++;
      stall = (i < 3);
      @(negedge clk);
    end
    stall = 1'b0;
    checkOutput("rd_stb_cycles", stbCnt, 4);
    checkOutput("rd_wait_cyc", cyc, 1);
    ack = 1'b1; datI = 32'h12345678;
    @(negedge clk);
    ack = 1'b0; datI = 32'h0;
    checkOutput("rd_cyc_drop", cyc, 0);
    recvByte("rd_b0", 8'hA5, 1'b0);
    recvByte("rd_b1", 8'h12, 1'b0);
    recvByte("rd_b2", 8'h34, 1'b0);
    recvByte("rd_b3", 8'h56, 1'b0);
    recvByte("rd_b4", 8'h78, 1'b0);
    checkOutput("rd_no_extra", txVld, 0);

    // Zero-wait slave: ack alongside the first unstalled strobe
    sendRead(32'h00000020);
    ack = 1'b1; datI = 32'hCAFEF00D;
    @(negedge clk);
    ack = 1'b0; datI = 32'h0;
    checkOutput("zw_cyc_drop", cyc, 0);
    checkOutput("zw_txvld", txVld, 1);
    recvByte("zw_b0", 8'hA5, 1'b0);
    recvByte("zw_b1", 8'hCA, 1'b0);
    recvByte("zw_b2", 8'hFE, 1'b0);
    recvByte("zw_b3", 8'hF0, 1'b0);
    recvByte("zw_b4", 8'h0D, 1'b0);

    // Read terminated by err on the first WAIT cycle
    sendRead(32'h00000040);
    @(negedge clk);
    err = 1'b1;
    @(negedge clk);
    err = 1'b0;
    checkOutput("err_cyc_drop", cyc, 0);
    recvByte("err_status", 8'hEE, 1'b0);
    checkOutput("err_no_extra", txVld, 0);

    // ack and err together: ack wins
    sendWrite(32'h00000008, 32'h11223344);
    @(negedge clk);
    ack = 1'b1; err = 1'b1;
    @(negedge clk);
    ack = 1'b0; err = 1'b0;
    recvByte("prio_status", 8'hA5, 1'b0);
    checkOutput("prio_no_extra", txVld, 0);

    // Stray ack while idle is ignored
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    checkOutput("stray_txvld", txVld, 0);
    checkOutput("stray_rxrdy", rxRdy, 1);

    // Junk byte dropped, then read with a throttled response consumer
    applyStimulus(8'h7F);
    checkOutput("junk_rxrdy", rxRdy, 1);
    checkOutput("junk_cyc", cyc, 0);
    sendRead(32'h03000000);
    checkOutput("thr_adr", adr, 32'h03000000);
    ack = 1'b1; datI = 32'hA1B2C3D4;
    @(negedge clk);
    ack = 1'b0; datI = 32'h0;
    recvByte("thr_b0", 8'hA5, 1'b1);
    recvByte("thr_b1", 8'hA1, 1'b1);
    recvByte("thr_b2", 8'hB2, 1'b1);
    recvByte("thr_b3", 8'hC3, 1'b1);
    recvByte("thr_b4", 8'hD4, 1'b1);
    checkOutput("thr_no_extra", txVld, 0);

    // Silent slave
    sendRead(32'h00000100);
    cycCnt = 0;
`ifdef WB_CMD_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      if (cyc) cycCnt++;
      @(negedge clk);
    end
    checkOutput("to_cyc_cycles", cycCnt, 16);
    recvByte("to_status", 8'hE0, 1'b0);
    checkOutput("to_no_extra", txVld, 0);
`else
    for (int i = 0; i < 1000; i++) begin
      if (cyc) cycCnt++;
      @(negedge clk);
    end
    checkOutput("noto_cyc_cycles", cycCnt, 1000);
    checkOutput("noto_txvld", txVld, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    // Reset pulse while waiting for the slave, then a clean frame
    sendRead(32'h00000200);
    @(negedge clk);
    checkOutput("rw_wait_cyc", cyc, 1);
    rst = 1'b1;
    #1;
    checkOutput("rw_cyc", cyc, 0);
    checkOutput("rw_stb", stb, 0);
    checkOutput("rw_txvld", txVld, 0);
    checkOutput("rw_rxrdy", rxRdy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rw_rel_rxrdy", rxRdy, 1);
    checkOutput("rw_rel_txvld", txVld, 0);
    sendRead(32'h00000000);
    checkOutput("rw2_adr", adr, 32'h00000000);
    @(negedge clk);
    ack = 1'b1; datI = 32'h55AA0FF0;
    @(negedge clk);
    ack = 1'b0; datI = 32'h0;
    recvByte("rw2_b0", 8'hA5, 1'b0);
    recvByte("rw2_b1", 8'h55, 1'b0);
    recvByte("rw2_b2", 8'hAA, 1'b0);
    recvByte("rw2_b3", 8'h0F, 1'b0);
    recvByte("rw2_b4", 8'hF0, 1'b0);
    checkOutput("rw2_no_extra", txVld, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
